// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths, default latency and FSM state type for dmem_responder
package dmem_pkg;
  localparam int DMEM_DATA_W = 64;
  localparam int DMEM_ADDR_W = 64;
  localparam int DMEM_LATENCY = 2;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 64-bit storage, synchronous write and registered read, no reset
// Ports: clock; i_en access strobe; i_we store/load select; i_idx doubleword index;
//        i_wdata store data; o_rdata data of the last load access.
module dmem_array import dmem_pkg::*; #(
  parameter int DEPTH = 256
) (
  input  logic                     clock,
  input  logic                     i_en,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_idx,
  input  logic [DMEM_DATA_W-1:0]   i_wdata,
  output logic [DMEM_DATA_W-1:0]   o_rdata
);
  logic [DMEM_DATA_W-1:0] r_mem [DEPTH];
  logic [DMEM_DATA_W-1:0] r_rdata;
  always_ff @(posedge clock) begin
    if (i_en && i_we) r_mem[i_idx] <= i_wdata;
    if (i_en && !i_we) r_rdata <= r_mem[i_idx];
  end
  assign o_rdata = r_rdata;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data memory responder for a pipeline mem stage
// Ports: clock, reset (async active-low); req_valid/req_write/req_addr/req_wdata request;
//        req_ready accept window; resp_valid/resp_rdata/err one-cycle response; stall hold.
// Build option: DMEM_MISALIGN_CHECK_EN faults accesses with addr[2:0] != 0.
module dmem_responder import dmem_pkg::*; #(
  parameter int DEPTH = 256,
  parameter int LATENCY = DMEM_LATENCY
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic                   req_write,
  input  logic [DMEM_ADDR_W-1:0] req_addr,
  input  logic [DMEM_DATA_W-1:0] req_wdata,
  output logic                   req_ready,
  output logic                   resp_valid,
  output logic [DMEM_DATA_W-1:0] resp_rdata,
  output logic                   stall,
  output logic                   err
);
  localparam int IW = $clog2(DEPTH);
  state_t r_state;
  logic [3:0] r_cnt;
  logic [DMEM_ADDR_W-1:0] r_addr;
  logic [DMEM_DATA_W-1:0] r_wdata;
  logic r_write, r_resp_valid, r_err, r_load;
  logic w_idle, w_fire, w_write, w_mis, w_unused;
  logic [DMEM_ADDR_W-1:0] w_addr;
  logic [DMEM_DATA_W-1:0] w_wdata, w_rdata;
  assign w_idle = r_state == IDLE;
  // with LATENCY=1 the access happens on the accepting edge, before the capture registers load
  assign w_addr = w_idle ? req_addr : r_addr;
  assign w_wdata = w_idle ? req_wdata : r_wdata;
  assign w_write = w_idle ? req_write : r_write;
  // edge that enters RESP: direct from IDLE at LATENCY=1, else the edge the counter reaches 0
  assign w_fire = (w_idle && req_valid && LATENCY == 1) || (r_state == BUSY && r_cnt == 4'd1);
`ifdef DMEM_MISALIGN_CHECK_EN
  assign w_mis = w_addr[2:0] != 3'd0;
`else
  assign w_mis = 1'b0;
`endif
  assign w_unused = ^w_addr;
  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clock   (clock),
    .i_en    (w_fire && reset),
    .i_we    (w_write && !w_mis),
    .i_idx   (w_addr[3 +: IW]),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_addr <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_resp_valid <= 1'b0;
      r_err <= 1'b0;
      r_load <= 1'b0;
    end else begin
      r_resp_valid <= w_fire;
      r_err <= w_fire && w_mis;
      r_load <= w_fire && !w_write && !w_mis;
      case (r_state)
        IDLE: if (req_valid) begin
          r_addr <= req_addr;
          r_wdata <= req_wdata;
          r_write <= req_write;
          r_cnt <= 4'(LATENCY - 1);
          r_state <= LATENCY == 1 ? RESP : BUSY;
        end
        BUSY: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= RESP;
        end
        RESP: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign req_ready = w_idle;
  assign stall = !w_idle || (w_idle && req_valid);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_load ? w_rdata : '0;
  assign err = r_err;
endmodule
